// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: memory FSM encoding,
// status flag positions and the saturating counter helper.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } mem_state_e;

  localparam int unsigned RegIdxW = 4;
  localparam int unsigned CntW    = 16;

  // Status register bit positions
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] value);
    return (value == CntMax) ? value : value + {{(CntW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Data-hazard detection for the instruction in ID against EXE and MEM destinations.
// With forwarding only load-use hazards stall; without it any pending writeback does.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic               forward_en,
  input  logic [RegIdxW-1:0] src1,
  input  logic [RegIdxW-1:0] src2,
  input  logic               two_src,
  input  logic [RegIdxW-1:0] id_exe_dest,
  input  logic               id_exe_wb_en,
  input  logic               id_exe_mem_r_en,
  input  logic [RegIdxW-1:0] exe_mem_dest,
  input  logic               exe_mem_wb_en,
  output logic               hazard
);

  logic match_exe;
  logic match_mem;
  logic hazard_exe;
  logic hazard_mem;

  always_comb begin
    match_exe  = (src1 == id_exe_dest) || (two_src && (src2 == id_exe_dest));
    match_mem  = (src1 == exe_mem_dest) || (two_src && (src2 == exe_mem_dest));
    hazard_exe = match_exe && id_exe_wb_en && (id_exe_mem_r_en || !forward_en);
    hazard_mem = !forward_en && match_mem && exe_mem_wb_en;
    hazard     = hazard_exe || hazard_mem;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory-wait freeze FSM, branch flush, hazard stall,
// status register and saturating event counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               forward_en,
  input  logic [RegIdxW-1:0] src1,
  input  logic [RegIdxW-1:0] src2,
  input  logic               two_src,
  input  logic [RegIdxW-1:0] id_exe_dest,
  input  logic               id_exe_wb_en,
  input  logic               id_exe_mem_r_en,
  input  logic [RegIdxW-1:0] exe_mem_dest,
  input  logic               exe_mem_wb_en,
  input  logic               branch_taken,
  input  logic               s_bit,
  input  logic [3:0]         alu_status,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               freeze_pc,
  output logic               freeze_if_id,
  output logic               flush_if_id,
  output logic               bubble_id_exe,
  output logic               freeze_all,
  output logic [3:0]         sr,
  output logic [CntW-1:0]    stall_cnt,
  output logic [CntW-1:0]    flush_cnt
);

  mem_state_e state;
  logic       hazard;
  logic       mem_stall;

  hazard_detect u_hazard_detect (
    .forward_en      (forward_en),
    .src1            (src1),
    .src2            (src2),
    .two_src         (two_src),
    .id_exe_dest     (id_exe_dest),
    .id_exe_wb_en    (id_exe_wb_en),
    .id_exe_mem_r_en (id_exe_mem_r_en),
    .exe_mem_dest    (exe_mem_dest),
    .exe_mem_wb_en   (exe_mem_wb_en),
    .hazard          (hazard)
  );

  // A request completing in the same cycle it is issued never freezes
  always_comb begin
    unique case (state)
      StRun:     mem_stall = mem_req && !mem_ready;
      StMemWait: mem_stall = !mem_ready;
      default:   mem_stall = 1'b0;
    endcase
  end

  // Priority: memory freeze, then taken branch, then data hazard
  always_comb begin
    freeze_all    = 1'b0;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    if (!rst) begin
      freeze_all = mem_stall;
      if (!mem_stall) begin
        if (branch_taken) begin
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (hazard) begin
          freeze_pc     = 1'b1;
          freeze_if_id  = 1'b1;
          bubble_id_exe = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StRun;
      sr        <= 4'b0000;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        StRun:     if (mem_req && !mem_ready) state <= StMemWait;
        StMemWait: if (mem_ready) state <= StRun;
        default:   state <= StRun;
      endcase
      if (s_bit && !freeze_all) begin
        sr[FlagN] <= alu_status[FlagN];
        sr[FlagZ] <= alu_status[FlagZ];
        sr[FlagC] <= alu_status[FlagC];
        sr[FlagV] <= alu_status[FlagV];
      end
      if (freeze_pc)   stall_cnt <= sat_inc(stall_cnt);
      if (flush_if_id) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
